// File: rtl/fpaddsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpaddsub_pkg
// Purpose : Shared widths, result record and opcodes for the FPAddSub front end.
// Revision: 1.0
// ============================================================================
package fpaddsub_pkg;

    localparam int FP_W   = 32;
    localparam int FLAG_W = 5;

    typedef logic [FP_W-1:0] fp_word_t;

    typedef struct packed {
        fp_word_t            result;
        logic [FLAG_W-1:0]   flags;
    } fp_res_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fpaddsub_res_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fpaddsub_res_fifo
// Purpose : First-word-fall-through result FIFO; dout reads zero when empty.
// Revision: 1.0
// ============================================================================
module fpaddsub_res_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign w_rd = pop && (r_count != '0);
    assign w_wr = push && ((r_count != CW'(DEPTH)) || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

    assign valid = (r_count != '0);
    assign dout  = valid ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fpaddsub_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fpaddsub_issue_ctrl
// Purpose : Credit-based issue/collect wrapper around the fixed-latency FPAddSub.
//           Optional request tags: define FPADDSUB_TAG_EN.
// Revision: 1.0
// ============================================================================
module fpaddsub_issue_ctrl
    import fpaddsub_pkg::*;
#(
    parameter int LATENCY    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_a,
    input  logic [FP_W-1:0]   in_b,
    input  logic              in_op,
`ifdef FPADDSUB_TAG_EN
    input  logic [TAG_W-1:0]  in_tag,
`endif
    output logic [FP_W-1:0]   fp_a,
    output logic [FP_W-1:0]   fp_b,
    output logic              fp_operation,
    input  logic [FP_W-1:0]   fp_result,
    input  logic [FLAG_W-1:0] fp_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   out_result,
    output logic [FLAG_W-1:0] out_flags,
`ifdef FPADDSUB_TAG_EN
    output logic [TAG_W-1:0]  out_tag,
`endif
    output logic              busy
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
`ifdef FPADDSUB_TAG_EN
    localparam int ENTRY_W = $bits(fp_res_t) + TAG_W;
`else
    // No tag field in this build; TAG_W stays so both builds share one parameter list.
    localparam int ENTRY_W = $bits(fp_res_t) + 0 * TAG_W;
`endif

    logic [FP_W-1:0]    r_fp_a;
    logic [FP_W-1:0]    r_fp_b;
    logic               r_fp_op;
    logic [LATENCY:0]   r_vld;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      w_fifo_cnt;
    logic [CW:0]        w_occ;
    logic               w_fire;
    logic               w_capture;
    logic               w_pop;
    fp_res_t            w_capt_res;
    fp_res_t            w_head_res;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;

    // Every fired op owns a FIFO slot until popped, so a capture never finds the FIFO full.
    assign w_occ     = {1'b0, r_inflight} + {1'b0, w_fifo_cnt};
    assign in_ready  = !rst && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign w_fire    = in_valid && in_ready;
    assign w_capture = r_vld[LATENCY];
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fp_a  <= '0;
            r_fp_b  <= '0;
            r_fp_op <= OP_ADD;
        end else if (w_fire) begin
            r_fp_a  <= in_a;
            r_fp_b  <= in_b;
            r_fp_op <= (in_op == OP_SUB) ? OP_SUB : OP_ADD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld      <= '0;
            r_inflight <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-1:0], w_fire};
            case ({w_fire, w_capture})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign w_capt_res = '{result: fp_result, flags: fp_flags};

`ifdef FPADDSUB_TAG_EN
    logic [LATENCY:0][TAG_W-1:0] r_tag_sr;

    // Tags ride alongside r_vld so each one lands with its own result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tag_sr <= '0;
        else     r_tag_sr <= {r_tag_sr[LATENCY-1:0], in_tag};
    end

    assign w_push_data           = {w_capt_res, r_tag_sr[LATENCY]};
    assign {w_head_res, out_tag} = w_head;
`else
    assign w_push_data = w_capt_res;
    assign w_head_res  = w_head;
`endif

    fpaddsub_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_capture),
        .din   (w_push_data),
        .pop   (w_pop),
        .dout  (w_head),
        .valid (out_valid),
        .count (w_fifo_cnt)
    );

    assign fp_a         = r_fp_a;
    assign fp_b         = r_fp_b;
    assign fp_operation = r_fp_op;
    assign out_result   = w_head_res.result;
    assign out_flags    = w_head_res.flags;
    assign busy         = (r_inflight != '0) || (w_fifo_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_fpaddsub_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpaddsub_issue_ctrl
// Purpose : Self-checking bench with a queue-based reference and an FPAddSub stand-in.
// Revision: 1.0
// ============================================================================
module tb_fpaddsub_issue_ctrl;
    import fpaddsub_pkg::*;

    localparam int LATENCY    = 5;
    localparam int FIFO_DEPTH = 8;
    localparam int TAG_W      = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [FP_W-1:0]   in_a = '0;
    logic [FP_W-1:0]   in_b = '0;
    logic              in_op = 1'b0;
    logic [FP_W-1:0]   fp_a;
    logic [FP_W-1:0]   fp_b;
    logic              fp_operation;
    logic [FP_W-1:0]   fp_result;
    logic [FLAG_W-1:0] fp_flags;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [FP_W-1:0]   out_result;
    logic [FLAG_W-1:0] out_flags;
    logic              busy;
`ifdef FPADDSUB_TAG_EN
    logic [TAG_W-1:0]  in_tag = '0;
    logic [TAG_W-1:0]  out_tag;
`endif

    fpaddsub_issue_ctrl #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
`ifdef FPADDSUB_TAG_EN
        .in_tag       (in_tag),
`endif
        .fp_a         (fp_a),
        .fp_b         (fp_b),
        .fp_operation (fp_operation),
        .fp_result    (fp_result),
        .fp_flags     (fp_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
`ifdef FPADDSUB_TAG_EN
        .out_tag      (out_tag),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Single-precision add/sub via double arithmetic (normal operands only).
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [30:0] mag;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e   = d[62:52] - 11'd896;
        mag = {e[7:0], d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) mag = mag + 31'd1;
        return {d[63], mag};
    endfunction

    function automatic logic [36:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [31:0] res;
        res = r2sp(op ? (sp2r(a) - sp2r(b)) : (sp2r(a) + sp2r(b)));
        return {res, res[4:0] ^ {op, a[3:0]}};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = 8'($urandom_range(154, 100));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // FPAddSub stand-in: fixed latency, no reset, no valid.
    logic [36:0] pipe [LATENCY];
    always @(posedge clk) begin
        pipe[0] <= unit_fn(fp_a, fp_b, fp_operation);
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign {fp_result, fp_flags} = pipe[LATENCY-1];

    typedef struct {
        logic [31:0]      res;
        logic [4:0]       flg;
        logic [TAG_W-1:0] tag;
        int               rdy;
    } exp_t;

    exp_t q[$];
    exp_t e_head;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic e_in_ready, e_out_valid, e_busy;

    // Reference: every fired request is outstanding until popped; it becomes
    // visible LATENCY+2 cycles after its fire cycle, strictly in order.
    task automatic sample();
        @(negedge clk);
        e_in_ready  = !rst && (q.size() < FIFO_DEPTH);
        e_busy      = (q.size() > 0);
        e_out_valid = 1'b0;
        if (q.size() > 0) begin
            e_head      = q[0];
            e_out_valid = (cyc >= q[0].rdy);
        end
    endtask

    task automatic advance();
        logic f, p;
        exp_t n;
        f = in_valid && e_in_ready;
        p = e_out_valid && out_ready;
        {n.res, n.flg} = unit_fn(in_a, in_b, in_op);
`ifdef FPADDSUB_TAG_EN
        n.tag = in_tag;
`else
        n.tag = '0;
`endif
        n.rdy = cyc + LATENCY + 2;
        @(posedge clk);
        if (p) void'(q.pop_front());
        if (f) q.push_back(n);
        if (rst) q.delete();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        sample();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL reset_valid_busy got=%b exp=00", {out_valid, busy}); end
        checks++; if ({fp_a, fp_b, fp_operation} !== 65'd0) begin failures++; $display("FAIL reset_fp got=%h exp=0", {fp_a, fp_b, fp_operation}); end
        checks++; if ({out_result, out_flags} !== 37'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", {out_result, out_flags}); end
        advance();
        advance();
        rst = 1'b0;
        sample();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        advance();
    endtask

    task automatic test_single();
        int t0;
        in_valid = 1'b1; in_a = 32'h4108815B; in_b = 32'h40472F14; in_op = 1'b1; out_ready = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 12; k++) begin
            sample();
            checks++; if (in_ready !== e_in_ready) begin failures++; $display("FAIL single_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_in_ready); end
            checks++; if (out_valid !== e_out_valid) begin failures++; $display("FAIL single_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid); end
            if (e_out_valid) begin
                checks++; if ({out_result, out_flags} !== {e_head.res, e_head.flg}) begin failures++; $display("FAIL single_data got=%h exp=%h", {out_result, out_flags}, {e_head.res, e_head.flg}); end
            end
            if (cyc == t0 + 1) begin
                checks++; if ({fp_a, fp_b, fp_operation} !== {32'h4108815B, 32'h40472F14, 1'b1}) begin failures++; $display("FAIL single_issue got=%h exp=%h", {fp_a, fp_b, fp_operation}, {32'h4108815B, 32'h40472F14, 1'b1}); end
            end
            if (cyc == t0 + 6) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", out_valid); end
            end
            if (cyc == t0 + 7) begin
                checks++; if ({out_valid, out_result} !== {1'b1, 32'h40AD6B2C}) begin failures++; $display("FAIL single_result got=%b/%h exp=1/40ad6b2c", out_valid, out_result); end
            end
            advance();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0, npop = 0, first = -1, last = -1;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_valid = (issued < 10);
            if (issued == 3) begin in_a = 32'h3F800000; in_b = 32'h3F800000; in_op = 1'b0; end
            else begin in_a = rand_fp(); in_b = rand_fp(); in_op = 1'($urandom); end
            sample();
            checks++; if (in_ready !== e_in_ready) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_in_ready); end
            checks++; if (out_valid !== e_out_valid) begin failures++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid); end
            if (e_out_valid) begin
                checks++; if ({out_result, out_flags} !== {e_head.res, e_head.flg}) begin failures++; $display("FAIL b2b_data got=%h exp=%h", {out_result, out_flags}, {e_head.res, e_head.flg}); end
                if (npop == 3) begin
                    checks++; if (out_result !== 32'h40000000) begin failures++; $display("FAIL b2b_one_plus_one got=%h exp=40000000", out_result); end
                end
                if (first < 0) first = cyc;
                last = cyc;
                npop++;
            end
            if (in_valid && e_in_ready) issued++;
            advance();
        end
        checks++; if (npop != 10 || last - first != 9) begin failures++; $display("FAIL b2b_stream got=%0d pops over %0d cycles exp=10 over 10", npop, last - first + 1); end
    endtask

    task automatic test_backpressure();
        int fires = 0, npop = 0, first = -1;
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; in_a = rand_fp(); in_b = rand_fp(); in_op = 1'($urandom);
            sample();
            checks++; if (in_ready !== e_in_ready) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_in_ready); end
            checks++; if (out_valid !== e_out_valid) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid); end
            if (in_ready === 1'b1) fires++;
            advance();
        end
        checks++; if (fires != FIFO_DEPTH) begin failures++; $display("FAIL bp_fires got=%0d exp=%0d", fires, FIFO_DEPTH); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sample();
            checks++; if (out_valid !== e_out_valid) begin failures++; $display("FAIL bp_drain_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid); end
            if (first >= 0 && cyc == first + 1) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_rise got=%b exp=1", in_ready); end
            end
            if (e_out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_at_first_pop got=%b exp=0", in_ready); end
                end
                checks++; if ({out_result, out_flags} !== {e_head.res, e_head.flg}) begin failures++; $display("FAIL bp_data got=%h exp=%h", {out_result, out_flags}, {e_head.res, e_head.flg}); end
                npop++;
            end
            advance();
        end
        checks++; if (npop != FIFO_DEPTH) begin failures++; $display("FAIL bp_drained got=%0d exp=%0d", npop, FIFO_DEPTH); end
    endtask

    task automatic test_wrap_random();
        int pops = 0;
        for (int k = 0; k < 400 && pops < 30; k++) begin
            in_valid = ($urandom % 4) != 0; in_a = rand_fp(); in_b = rand_fp(); in_op = 1'($urandom);
            out_ready = 1'($urandom);
            sample();
            checks++; if (in_ready !== e_in_ready) begin failures++; $display("FAIL wrap_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_in_ready); end
            checks++; if ({out_valid, busy} !== {e_out_valid, e_busy}) begin failures++; $display("FAIL wrap_valid_busy cyc=%0d got=%b exp=%b", cyc, {out_valid, busy}, {e_out_valid, e_busy}); end
            if (e_out_valid) begin
                checks++; if ({out_result, out_flags} !== {e_head.res, e_head.flg}) begin failures++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cyc, {out_result, out_flags}, {e_head.res, e_head.flg}); end
                if (out_ready) pops++;
            end
            advance();
        end
        checks++; if (pops != 30) begin failures++; $display("FAIL wrap_pops got=%0d exp=30", pops); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            sample();
            checks++; if ({out_valid, busy} !== {e_out_valid, e_busy}) begin failures++; $display("FAIL wrap_drain cyc=%0d got=%b exp=%b", cyc, {out_valid, busy}, {e_out_valid, e_busy}); end
            if (e_out_valid) begin
                checks++; if ({out_result, out_flags} !== {e_head.res, e_head.flg}) begin failures++; $display("FAIL wrap_drain_data got=%h exp=%h", {out_result, out_flags}, {e_head.res, e_head.flg}); end
            end
            advance();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_inflight();
        logic reached = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_a = rand_fp(); in_b = rand_fp(); in_op = 1'($urandom);
            sample();
            checks++; if (in_ready !== e_in_ready) begin failures++; $display("FAIL rstf_in_ready got=%b exp=%b", in_ready, e_in_ready); end
            advance();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sample();
            checks++; if (out_valid !== e_out_valid) begin failures++; $display("FAIL rstf_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid); end
            if (q.size() >= 2 && cyc >= q[1].rdy) begin reached = 1'b1; break; end
            advance();
        end
        checks++; if (!reached) begin failures++; $display("FAIL rstf_setup got=not_reached exp=two_in_fifo"); end
        #1 rst = 1'b1;
        #1;
        checks++; if ({out_valid, busy, in_ready} !== 3'b000) begin failures++; $display("FAIL rstf_immediate got=%b exp=000", {out_valid, busy, in_ready}); end
        q.delete();
        advance();
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            sample();
            checks++; if ({in_ready, out_valid, busy} !== {e_in_ready, e_out_valid, e_busy}) begin failures++; $display("FAIL rstf_after cyc=%0d got=%b exp=%b", cyc, {in_ready, out_valid, busy}, {e_in_ready, e_out_valid, e_busy}); end
            advance();
        end
    endtask

`ifdef FPADDSUB_TAG_EN
    task automatic test_tags();
        int next_tag = 0, npop = 0;
        for (int k = 0; k < 300 && npop < 10; k++) begin
            in_valid = (next_tag < 10); in_tag = TAG_W'(next_tag);
            in_a = rand_fp(); in_b = rand_fp(); in_op = 1'($urandom);
            out_ready = 1'($urandom);
            sample();
            checks++; if (out_valid !== e_out_valid) begin failures++; $display("FAIL tag_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid); end
            if (e_out_valid) begin
                checks++; if ({out_result, out_flags, out_tag} !== {e_head.res, e_head.flg, e_head.tag}) begin failures++; $display("FAIL tag_data got=%h exp=%h", {out_result, out_flags, out_tag}, {e_head.res, e_head.flg, e_head.tag}); end
                if (out_ready) begin
                    checks++; if (out_tag !== TAG_W'(npop)) begin failures++; $display("FAIL tag_order got=%0d exp=%0d", out_tag, npop); end
                    npop++;
                end
            end
            if (in_valid && e_in_ready) next_tag++;
            advance();
        end
        checks++; if (npop != 10) begin failures++; $display("FAIL tag_count got=%0d exp=10", npop); end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap_random();
        test_reset_inflight();
`ifdef FPADDSUB_TAG_EN
        test_tags();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpaddsub_issue_ctrl.md
Name: fpaddsub_issue_ctrl

Overview:
Issue/collect front end for the single-precision FPAddSub pipeline.
- Accepts add/sub requests on a valid/ready stream and drives the operands into FPAddSub, whose pipeline has fixed latency and no valid or stall.
- Tracks in-flight ops with a valid shift register and captures each result plus flags into a result FIFO.
- Credit-based issue guarantees the FIFO never overflows under downstream back-pressure.

Parameters:
- LATENCY, 5, FPAddSub cycles from registered a/b/operation to the corresponding result/flags.
- FIFO_DEPTH, 8, result FIFO entries (power of two, >= 2).
- TAG_W, 4, request tag width (used only with FPADDSUB_TAG_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_a  in  32  operand A (IEEE-754 single)
- in_b  in  32  operand B
- in_op  in  1  0 = A+B, 1 = A-B
- in_tag  in  TAG_W  request tag (FPADDSUB_TAG_EN only)
- fp_a  out  32  to FPAddSub a
- fp_b  out  32  to FPAddSub b
- fp_operation  out  1  to FPAddSub operation
- fp_result  in  32  from FPAddSub result
- fp_flags  in  5  from FPAddSub flags
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_result  out  32  result, FIFO head
- out_flags  out  5  flags, FIFO head
- out_tag  out  TAG_W  echoed tag (FPADDSUB_TAG_EN only)
- busy  out  1  any op in flight or any FIFO entry held

Behaviour:
- Reset (async, rst=1):
  - fp_a, fp_b, fp_operation = 0.
  - Valid shift register cleared; FIFO emptied.
  - out_valid = 0, busy = 0, out_result/out_flags/out_tag = 0.
  - in_ready = 0 while rst is high, 1 in the first cycle after release.
  - Ops in flight at reset are discarded; stale fp_result values are never captured.
- Issue: fire = in_valid && in_ready.
  - On fire, fp_a/fp_b/fp_operation register in_a/in_b/in_op; otherwise they hold.
  - Held values recirculate through FPAddSub but are ignored.
- Valid tracking: shift register vld[LATENCY:0].
  - vld[0] = fire, registered.
  - vld[LATENCY] high means fp_result/fp_flags belong to that issue.
- Capture: when vld[LATENCY] is high, {fp_result, fp_flags[, tag]} is written to the FIFO tail at that edge.
  - Tags travel in a parallel TAG_W-wide shift register.
- Latency: request fired in cycle t appears as out_valid in cycle t+LATENCY+2 (FIFO empty, out_ready high).
- Throughput: one op per cycle sustained while out_ready stays high.
- Credits: occupancy = inflight_cnt + fifo_cnt; in_ready = (occupancy < FIFO_DEPTH).
  - inflight_cnt: +1 on fire, -1 on capture.
  - fifo_cnt: +1 on capture, -1 on pop.
  - Simultaneous events net out in the same cycle.
  - A capture can never find the FIFO full.
- Output: first-word-fall-through. out_* reflect the FIFO head whenever out_valid is high; they are stable while out_valid && !out_ready.
- FIFO empty: out_valid = 0. Capture and pop never coincide on an empty FIFO; data is visible one cycle after capture.
- FIFO full: capture and pop in the same cycle are legal; order is preserved and pointers wrap modulo FIFO_DEPTH.
- Ordering: results emerge strictly in issue order.
- No arithmetic in this block; results and flags pass through bit-exact.

Optional Feature:
Macro: FPADDSUB_TAG_EN.
- Defined: in_tag/out_tag ports exist; the tag is carried alongside vld and stored in the FIFO.
- Undefined: tag ports, tag shift register and tag FIFO field are absent. TAG_W is unused.

Decomposition:
- Package fpaddsub_pkg: FP_W=32, FLAG_W=5, typedef fp_word_t, typedef fp_res_t {result, flags}, opcode constants OP_ADD=0 and OP_SUB=1.
- Sub-module fpaddsub_res_fifo: synchronous FWFT FIFO, parameters DEPTH and W, push/pop/count, async active-high rst.

Test Plan:
- Single op, LATENCY=5: a=0x4108815B, b=0x40472F14, op=1 fired at cycle 0 -> out_valid at cycle 7 with out_result=0x40AD6B2C.
- Back-to-back: 10 ops fired on consecutive cycles, out_ready=1 -> 10 results on consecutive cycles in order. One of them is a=0x3F800000, b=0x3F800000, op=0 -> 0x40000000.
- Back-pressure: out_ready=0, in_valid=1 continuous -> exactly FIFO_DEPTH (8) fires; in_ready drops after the 8th fire. Then out_ready=1 -> 8 results drained in order; in_ready rises the cycle after the first pop.
- Full FIFO with capture+pop in the same cycle -> no loss or duplication; fifo_cnt unchanged; pointer wrap verified over 3 full cycles of the FIFO.
- rst asserted with 3 ops in flight and 2 held in the FIFO -> out_valid=0 and busy=0 immediately. After release no stale result appears; in_ready=1.
- With FPADDSUB_TAG_EN, tags 0..9 issued and out_ready toggled randomly -> out_tag sequence is 0..9, each aligned with its own result.
